maze_tile_renderer: RTL and testbench

MAZE_TILE_RENDERER -- requirements
Module: maze_tile_renderer

---
 rtl/maze_pkg.sv | 44 ++++
 rtl/maze_tile_renderer_if.sv | 16 +
 rtl/maze_sync_delay.sv | 53 +++++
 rtl/maze_tile_renderer.sv | 189 ++++++++++++++++++
 tb/tb_maze_tile_renderer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
//==============================================================================
// Package : maze_pkg
// Brief   : Tile-type encodings, colour constants and renderer FSM state type.
// Rev     : 1.0  initial release
//==============================================================================
package maze_pkg;

    typedef enum logic [1:0] {
        TILE_WALL  = 2'd0,
        TILE_PATH  = 2'd1,
        TILE_START = 2'd2,
        TILE_GOAL  = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    // 3-3-2 packed RGB
    localparam logic [7:0] c_rgb_wall  = 8'h00;
    localparam logic [7:0] c_rgb_path  = 8'hFF;
    localparam logic [7:0] c_rgb_start = 8'h1C;
    localparam logic [7:0] c_rgb_goal  = 8'hE0;
    localparam logic [7:0] c_rgb_bg    = 8'h03;
    localparam logic [7:0] c_rgb_grid  = 8'h92;

    function automatic logic [7:0] tile_rgb(input tile_t tile);
        logic [7:0] rgb;
        rgb = c_rgb_wall;
        case (tile)
            TILE_WALL:  rgb = c_rgb_wall;
            TILE_PATH:  rgb = c_rgb_path;
            TILE_START: rgb = c_rgb_start;
            TILE_GOAL:  rgb = c_rgb_goal;
            default:    rgb = c_rgb_wall;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_tile_renderer_if.sv
`default_nettype none
//==============================================================================
// Interface : maze_tile_renderer_if
// Brief     : Tile RAM read bus between the renderer (master) and the maze RAM.
// Rev       : 1.0  initial release
//==============================================================================
interface maze_tile_renderer_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] cell_addr;
    logic [1:0]        cell_data;

    modport master (output cell_addr, input  cell_data);
    modport slave  (input  cell_addr, output cell_data);
endinterface
`default_nettype wire

// File: rtl/maze_sync_delay.sv
`default_nettype none
//==============================================================================
// Module : maze_sync_delay
// Brief  : p_tick-gated delay line keeping hsync/vsync/video_on aligned to rgb.
// Rev    : 1.0  initial release
//==============================================================================
module maze_sync_delay #(
    parameter int DEPTH = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_p_tick,
    input  wire logic i_hsync,
    input  wire logic i_vsync,
    input  wire logic i_video_on,
    output logic      o_hsync,
    output logic      o_vsync,
    output logic      o_video_on
);
    logic [DEPTH-1:0] hs_q, hs_d;
    logic [DEPTH-1:0] vs_q, vs_d;
    logic [DEPTH-1:0] vid_q, vid_d;

    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        vid_d = vid_q;
        if (i_p_tick) begin
            hs_d  = {hs_q[DEPTH-2:0],  i_hsync};
            vs_d  = {vs_q[DEPTH-2:0],  i_vsync};
            vid_d = {vid_q[DEPTH-2:0], i_video_on};
        end
    end

    // Syncs idle high, so they reset high; blanking resets low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= '1;
            vs_q  <= '1;
            vid_q <= '0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vid_q <= vid_d;
        end
    end

    assign o_hsync    = hs_q[DEPTH-1];
    assign o_vsync    = vs_q[DEPTH-1];
    assign o_video_on = vid_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/maze_tile_renderer.sv
`default_nettype none
//==============================================================================
// Module : maze_tile_renderer
// Brief  : 3-stage tile-map renderer (geometry, RAM read, colour) with frame FSM.
// Config : define MAZE_GRID_EN to draw grid lines on each tile's first row/col.
// Rev    : 1.0  initial release
//==============================================================================
module maze_tile_renderer
    import maze_pkg::*;
#(
    parameter int TILE_SHIFT = 4,
    parameter int MAZE_MAX   = 32,
    parameter int COLOR_W    = 8
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       enable,
    input  wire logic                       p_tick,
    input  wire logic [9:0]                 pixel_x,
    input  wire logic [9:0]                 pixel_y,
    input  wire logic                       video_on,
    input  wire logic                       hsync,
    input  wire logic                       vsync,
    input  wire logic [9:0]                 x_coord,
    input  wire logic [9:0]                 y_coord,
    input  wire logic [$clog2(MAZE_MAX):0]  maze_width,
    input  wire logic [$clog2(MAZE_MAX):0]  maze_height,
    maze_tile_renderer_if.master            ram,
    output logic [COLOR_W-1:0]              rgb_out,
    output logic                            hsync_out,
    output logic                            vsync_out
);
    localparam int DIM_W  = $clog2(MAZE_MAX) + 1;
    localparam int ADDR_W = 2 * $clog2(MAZE_MAX);
    localparam logic [DIM_W-1:0] c_dim_max = DIM_W'(MAZE_MAX);

    state_t                  state_q, state_d;
    logic                    vs_prev_q, vs_prev_d;
    logic [9:0]              org_x_q, org_x_d, org_y_q, org_y_d;
    logic [DIM_W-1:0]        width_q, width_d, height_q, height_d;
    logic                    frame_start;

    logic signed [10:0]      dx, dy, tile_col, tile_row;
    logic                    in_maze;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    s1_draw_q, s1_draw_d;
    tile_t                   s2_tile_q, s2_tile_d;
    logic                    s2_draw_q, s2_draw_d;
    logic [COLOR_W-1:0]      rgb_q, rgb_d;
    logic                    video_on_dly;

    assign frame_start = p_tick && vs_prev_q && !vsync;

    always_comb begin
        state_d = state_q;
        if (p_tick) begin
            case (state_q)
                ST_IDLE:  if (enable)                  state_d = ST_ARMED;
                ST_ARMED: if (frame_start)             state_d = ST_DRAW;
                ST_DRAW:  if (frame_start && !enable)  state_d = ST_IDLE;
                default:                               state_d = ST_IDLE;
            endcase
        end
    end

    // Geometry is frozen for a whole frame so mid-frame edits never tear it.
    always_comb begin
        vs_prev_d = p_tick ? vsync : vs_prev_q;
        org_x_d   = org_x_q;
        org_y_d   = org_y_q;
        width_d   = width_q;
        height_d  = height_q;
        if (frame_start) begin
            org_x_d  = x_coord;
            org_y_d  = y_coord;
            width_d  = (maze_width  > c_dim_max) ? c_dim_max : maze_width;
            height_d = (maze_height > c_dim_max) ? c_dim_max : maze_height;
        end
    end

    // Signed offsets: pixels left/above the origin go negative instead of wrapping.
    always_comb begin
        dx        = $signed({1'b0, pixel_x}) - $signed({1'b0, org_x_q});
        dy        = $signed({1'b0, pixel_y}) - $signed({1'b0, org_y_q});
        tile_col  = dx >>> TILE_SHIFT;
        tile_row  = dy >>> TILE_SHIFT;
        in_maze   = !tile_col[10] && !tile_row[10]
                    && (tile_col < $signed(11'(width_q)))
                    && (tile_row < $signed(11'(height_q)));
        addr_d    = addr_q;
        s1_draw_d = s1_draw_q;
        if (p_tick) begin
            if (in_maze) begin
                addr_d = ADDR_W'($unsigned(tile_row)) * ADDR_W'(MAZE_MAX)
                       + ADDR_W'($unsigned(tile_col));
            end
            s1_draw_d = in_maze && (state_q == ST_DRAW);
        end
    end

`ifdef MAZE_GRID_EN
    logic s1_grid_q, s1_grid_d, s2_grid_q, s2_grid_d;

    always_comb begin
        s1_grid_d = s1_grid_q;
        s2_grid_d = s2_grid_q;
        if (p_tick) begin
            s1_grid_d = (dx[TILE_SHIFT-1:0] == '0) || (dy[TILE_SHIFT-1:0] == '0);
            s2_grid_d = s1_grid_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_grid_q <= 1'b0;
            s2_grid_q <= 1'b0;
        end else begin
            s1_grid_q <= s1_grid_d;
            s2_grid_q <= s2_grid_d;
        end
    end
`endif

    always_comb begin
        s2_tile_d = s2_tile_q;
        s2_draw_d = s2_draw_q;
        rgb_d     = rgb_q;
        if (p_tick) begin
            s2_tile_d = tile_t'(ram.cell_data);
            s2_draw_d = s1_draw_q;
            if (!s2_draw_q) begin
                rgb_d = COLOR_W'(c_rgb_bg);
            end
`ifdef MAZE_GRID_EN
            else if (s2_grid_q) begin
                rgb_d = COLOR_W'(c_rgb_grid);
            end
`endif
            else begin
                rgb_d = COLOR_W'(tile_rgb(s2_tile_q));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            vs_prev_q <= 1'b1;
            org_x_q   <= '0;
            org_y_q   <= '0;
            width_q   <= '0;
            height_q  <= '0;
            addr_q    <= '0;
            s1_draw_q <= 1'b0;
            s2_tile_q <= TILE_WALL;
            s2_draw_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vs_prev_d;
            org_x_q   <= org_x_d;
            org_y_q   <= org_y_d;
            width_q   <= width_d;
            height_q  <= height_d;
            addr_q    <= addr_d;
            s1_draw_q <= s1_draw_d;
            s2_tile_q <= s2_tile_d;
            s2_draw_q <= s2_draw_d;
            rgb_q     <= rgb_d;
        end
    end

    maze_sync_delay #(.DEPTH(3)) u_sync_delay (
        .clk        (clk),
        .rst_n      (reset),
        .i_p_tick   (p_tick),
        .i_hsync    (hsync),
        .i_vsync    (vsync),
        .i_video_on (video_on),
        .o_hsync    (hsync_out),
        .o_vsync    (vsync_out),
        .o_video_on (video_on_dly)
    );

    assign ram.cell_addr = addr_q;
    assign rgb_out       = video_on_dly ? rgb_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_maze_tile_renderer.sv
`default_nettype none
//==============================================================================
// Module : tb_maze_tile_renderer
// Brief  : Randomised self-checking bench with a frame-level reference model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_maze_tile_renderer;

    localparam int TILE = 16;
    localparam int MM   = 32;
`ifdef MAZE_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, p_tick;
    logic [9:0] pixel_x, pixel_y, x_coord, y_coord;
    logic       video_on, hsync, vsync;
    logic [5:0] maze_width, maze_height;
    logic [7:0] rgb_out;
    logic       hsync_out, vsync_out;
    logic [1:0] mem [0:1023];

    maze_tile_renderer_if #(.ADDR_W(10)) ram_if ();
    assign ram_if.cell_data = mem[ram_if.cell_addr];

    maze_tile_renderer #(.TILE_SHIFT(4), .MAZE_MAX(32), .COLOR_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .p_tick(p_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .x_coord(x_coord), .y_coord(y_coord),
        .maze_width(maze_width), .maze_height(maze_height),
        .ram(ram_if),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame mode 0 idle / 1 armed / 2 drawing, geometry frozen per frame.
    int m_mode, m_ox, m_oy, m_w, m_h;
    bit m_prev_vs;

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        bit         has_want;
        logic [7:0] want;
        string      tag;
    } exp_t;
    exp_t q[$];

    function automatic bit ref_cell(input int px, input int py, output int addr);
        int dx, dy, w, h;
        dx = px - m_ox;
        dy = py - m_oy;
        w  = (m_w > MM) ? MM : m_w;
        h  = (m_h > MM) ? MM : m_h;
        addr = 0;
        if (dx < 0 || dy < 0) return 1'b0;
        if (dx / TILE >= w || dy / TILE >= h) return 1'b0;
        addr = (dy / TILE) * MM + dx / TILE;
        return 1'b1;
    endfunction

    function automatic logic [7:0] ref_rgb(input int px, input int py, input bit vid);
        int a;
        if (!vid) return 8'h00;
        if (m_mode != 2 || !ref_cell(px, py, a)) return 8'h03;
        if (GRID && ((((px - m_ox) % TILE) == 0) || (((py - m_oy) % TILE) == 0))) return 8'h92;
        case (mem[a])
            2'd0:    return 8'h00;
            2'd1:    return 8'hFF;
            2'd2:    return 8'h1C;
            default: return 8'hE0;
        endcase
    endfunction

    task automatic model_update(input bit vs);
        bit fall;
        fall = m_prev_vs && !vs;
        case (m_mode)
            0:       if (enable) m_mode = 1;
            1:       if (fall) m_mode = 2;
            default: if (fall && !enable) m_mode = 0;
        endcase
        if (fall) begin
            m_ox = x_coord;
            m_oy = y_coord;
            m_w  = maze_width;
            m_h  = maze_height;
        end
        m_prev_vs = vs;
    endtask

    task automatic model_reset();
        exp_t e;
        m_mode = 0; m_prev_vs = 1'b1;
        m_ox = 0; m_oy = 0; m_w = 0; m_h = 0;
        q.delete();
        e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1; e.has_want = 1'b0; e.want = 8'h00; e.tag = "";
        q.push_back(e);
        q.push_back(e);
    endtask

    // One pixel strobe, preceded by 0-2 stalled cycles with junk on the pixel bus.
    task automatic tick(input int px, input int py, input bit vid, input bit vs,
                        input bit has_want = 1'b0, input logic [7:0] want = 8'h00,
                        input string wtag = "");
        exp_t e;
        int   idle, a;
        bit   chk_addr;
        idle = $urandom_range(0, 2);
        repeat (idle) begin
            p_tick  = 1'b0;
            pixel_x = 10'($urandom);
            pixel_y = 10'($urandom);
            @(negedge clk);
        end
        pixel_x  = 10'(px);
        pixel_y  = 10'(py);
        video_on = vid;
        hsync    = 1'($urandom);
        vsync    = vs;
        p_tick   = 1'b1;
        e.rgb = ref_rgb(px, py, vid);
        e.hs = hsync; e.vs = vs; e.has_want = has_want; e.want = want; e.tag = wtag;
        chk_addr = (m_mode == 2) && ref_cell(px, py, a);
        model_update(vs);
        q.push_back(e);
        @(negedge clk);
        p_tick = 1'b0;
        if (chk_addr) check("cell_addr", 32'(ram_if.cell_addr), 32'(a));
        if (q.size() == 3) begin
            e = q.pop_front();
            check("rgb", 32'(rgb_out), 32'(e.rgb));
            check("hsync_out", 32'(hsync_out), 32'(e.hs));
            check("vsync_out", 32'(vsync_out), 32'(e.vs));
            if (e.has_want) check(e.tag, 32'(rgb_out), 32'(e.want));
        end
    endtask

    task automatic pix(input int px, input int py, input logic [7:0] want, input string tag);
        tick(px, py, 1'b1, 1'b1, 1'b1, want, tag);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) tick($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b1);
    endtask

    task automatic new_frame();
        for (int i = 0; i < 3; i++) tick($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'b0);
        blank(2);
    endtask

    task automatic active(input int n);
        int px, py;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                px = m_ox - 20 + $urandom_range(0, TILE * (MM + 3));
                py = m_oy - 20 + $urandom_range(0, TILE * (MM + 3));
                px = (px < 0) ? 0 : (px > 1023) ? 1023 : px;
                py = (py < 0) ? 0 : (py > 1023) ? 1023 : py;
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            tick(px, py, 1'b1, 1'b1);
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 1024; i++) mem[i] = rnd ? 2'($urandom) : 2'd1;
    endtask

    task automatic set_geom(input int x, input int y, input int w, input int h);
        x_coord = 10'(x); y_coord = 10'(y);
        maze_width = 6'(w); maze_height = 6'(h);
    endtask

    logic [7:0] path_org;

    initial begin
        path_org = GRID ? 8'h92 : 8'hFF;
        reset = 1'b0; enable = 1'b1; p_tick = 1'b0;
        pixel_x = '0; pixel_y = '0; video_on = 1'b0; hsync = 1'b1; vsync = 1'b1;
        set_geom(0, 0, 4, 4);
        fill_mem(1'b0);
        repeat (3) @(negedge clk);
        check("reset_rgb", 32'(rgb_out), 32'h00);
        check("reset_hsync", 32'(hsync_out), 32'h1);
        check("reset_vsync", 32'(vsync_out), 32'h1);
        check("reset_addr", 32'(ram_if.cell_addr), 32'h0);
        model_reset();
        reset = 1'b1;

        // Single wall tile in an otherwise open 4x4 maze at the origin
        mem[2 * MM + 1] = 2'd0;
        blank(2);
        new_frame();
        pix(20, 40, 8'h00, "req033_wall");
        pix(0, 0, path_org, "req033_origin");
        pix(31, 47, 8'h00, "req033_wall_corner");
        pix(64, 10, 8'h03, "req033_right_edge");
        active(30);

        // Origin near the right edge of the raster
        set_geom(600, 0, 4, 4);
        blank(3);
        fill_mem(1'b0);
        new_frame();
        pix(599, 5, 8'h03, "req034_left");
        pix(664, 5, 8'h03, "req034_right");
        pix(0, 5, 8'h03, "req034_x0");
        pix(663, 5, 8'hFF, "req034_last_col");
        pix(600, 5, path_org, "req038_tile_origin");
        active(30);

        // Width change mid-frame applies only from the next frame
        set_geom(0, 0, 4, 4);
        new_frame();
        pix(100, 5, 8'h03, "req036_old_width");
        maze_width = 6'd8;
        pix(100, 5, 8'h03, "req036_ignored");
        active(20);
        new_frame();
        pix(100, 5, 8'hFF, "req036_new_width");
        active(20);

        // Enable drop finishes the frame; enable raise waits for the next one
        enable = 1'b0;
        pix(20, 5, 8'hFF, "req035_drop_continue");
        active(10);
        new_frame();
        pix(20, 5, 8'h03, "req035_idle");
        enable = 1'b1;
        pix(20, 5, 8'h03, "req035_armed");
        active(10);
        new_frame();
        pix(20, 5, 8'hFF, "req035_next_frame");
        active(10);

        // Zero-sized maze
        set_geom(0, 0, 0, 4);
        new_frame();
        pix(5, 5, 8'h03, "req024_w0");
        active(15);
        set_geom(0, 0, 4, 0);
        new_frame();
        pix(5, 5, 8'h03, "req024_h0");
        active(15);

        // Oversized dimensions saturate
        set_geom(0, 0, 50, 63);
        blank(3);
        fill_mem(1'b1);
        mem[31] = 2'd3;
        new_frame();
        pix(650, 5, 8'h03, "req025_saturated");
        pix(500, 5, 8'hE0, "req025_last_col");
        active(30);

        // Random frames with mid-frame disturbances
        for (int f = 0; f < 6; f++) begin
            blank(3);
            fill_mem(1'b1);
            set_geom($urandom_range(0, 700), $urandom_range(0, 400),
                     $urandom_range(0, 40), $urandom_range(0, 40));
            enable = ($urandom_range(0, 3) != 0);
            new_frame();
            active(30);
            if ($urandom_range(0, 1) == 1) enable = ~enable;
            set_geom($urandom_range(0, 1023), $urandom_range(0, 1023),
                     $urandom_range(0, 63), $urandom_range(0, 63));
            active(30);
        end

        // Asynchronous reset in the middle of a drawn frame
        blank(3);
        fill_mem(1'b0);
        set_geom(0, 0, 4, 4);
        enable = 1'b1;
        new_frame();
        new_frame();
        active(10);
        pix(300, 200, 8'h03, "req037_before_reset");
        #2;
        reset = 1'b0;
        #1;
        check("req037_rst_rgb", 32'(rgb_out), 32'h00);
        check("req037_rst_hsync", 32'(hsync_out), 32'h1);
        check("req037_rst_vsync", 32'(vsync_out), 32'h1);
        check("req037_rst_addr", 32'(ram_if.cell_addr), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        active(10);
        pix(20, 5, 8'h03, "req037_rest_of_frame");
        active(5);
        new_frame();
        active(10);
        new_frame();
        pix(20, 5, 8'hFF, "req037_resumed");
        active(10);
        blank(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
